// File: rtl/keyb_pkg.sv
// Shared types and helpers for the keypad matrix scanner (keyb_scan_driver, keyb_matrix_scanner).
package keyb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } frame_t;

    // Bits needed to hold the values 0..n-1; never narrower than one bit.
    function automatic int code_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/keyb_scan_driver.sv
// Column drive, row sampling and per-frame summary for the keypad matrix scanner.
module keyb_scan_driver
    import keyb_pkg::*;
#(
    parameter int N_ROWS   = 4,
    parameter int N_COLS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int CODE_W   = code_width(N_ROWS * N_COLS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_ROWS-1:0]          row_in,
    output logic [N_COLS-1:0]          col_out,
    output logic                       frame_done,
    output frame_t                     frame_sum,
    output logic [CODE_W-1:0]          frame_code,
    output logic [N_ROWS*N_COLS-1:0]   frame_map
);

    localparam int N_KEYS = N_ROWS * N_COLS;
    localparam int DIV_W  = code_width(SCAN_DIV);
    localparam int COL_W  = code_width(N_COLS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS - 1);

    logic [DIV_W-1:0]  div_q;
    logic [COL_W-1:0]  col_q;
    logic [N_KEYS-1:0] acc_q;
    logic [N_KEYS-1:0] cur_map;
    logic              sample;

    assign sample     = (div_q == DIV_LAST);
    assign frame_done = sample && (col_q == COL_LAST);
    assign frame_map  = cur_map;

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q   <= '0;
            col_q   <= '0;
            col_out <= {{(N_COLS-1){1'b1}}, 1'b0};
            // NOTE: acc_q is fully rewritten before its first use, but it is
            // reset anyway so a frame summary is never built from X bits.
            acc_q   <= '0;
        end else if (sample) begin
            div_q   <= '0;
            col_q   <= (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
            col_out <= {col_out[N_COLS-2:0], col_out[N_COLS-1]};
            acc_q   <= cur_map;
        end else begin
            div_q   <= div_q + DIV_W'(1);
        end
    end

    // The closure map for the column being sampled replaces last frame's bits.
    always_comb begin
        cur_map = acc_q;
        for (int r = 0; r < N_ROWS; r++) begin
            cur_map[r*N_COLS + int'(col_q)] = ~row_in[r];
        end
    end

    // Lowest-index closure wins the code; a second closure marks the frame MULTI.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path
        // through this block can leave a value held (no inferred latch).
        frame_sum  = NONE;
        frame_code = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            if (cur_map[k]) begin
                if (frame_sum == NONE) begin
                    frame_sum  = SINGLE;
                    frame_code = CODE_W'(k);
                end else begin
                    frame_sum  = MULTI;
                end
            end
        end
    end

endmodule

// File: rtl/keyb_matrix_scanner.sv
// Keypad matrix scanner: debounce FSM, single-key lock and press-event handshake.
// Optional typematic repeat is enabled by defining KEYB_TYPEMATIC_EN.
module keyb_matrix_scanner
    import keyb_pkg::*;
#(
    parameter int N_ROWS          = 4,
    parameter int N_COLS          = 4,
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_RATE     = 10
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [N_ROWS-1:0]                        row_in,
    output logic [N_COLS-1:0]                        col_out,
    output logic [code_width(N_ROWS*N_COLS)-1:0]     key_code,
    output logic                                     event_valid,
    input  logic                                     event_ready,
    output logic                                     key_held,
    output logic                                     overflow
);

    localparam int N_KEYS = N_ROWS * N_COLS;
    localparam int CODE_W = code_width(N_KEYS);
    localparam int CNT_W  = code_width(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_FRAMES - 1);

    logic               frame_done;
    frame_t             frame_sum;
    logic [CODE_W-1:0]  frame_code;
    logic [N_KEYS-1:0]  frame_map;

    state_t             state_q, state_d;
    logic [CODE_W-1:0]  cand_q, cand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               key_held_d;
    logic               event_valid_d;
    logic [CODE_W-1:0]  key_code_d;
    logic               overflow_d;
    logic               accept;
    logic               repeat_fire;
    logic               cand_present;

    keyb_scan_driver #(
        .N_ROWS   (N_ROWS),
        .N_COLS   (N_COLS),
        .SCAN_DIV (SCAN_DIV),
        .CODE_W   (CODE_W)
    ) u_scan (
        .clk        (clk),
        .reset      (reset),
        .row_in     (row_in),
        .col_out    (col_out),
        .frame_done (frame_done),
        .frame_sum  (frame_sum),
        .frame_code (frame_code),
        .frame_map  (frame_map)
    );

    assign cand_present = frame_map[cand_q];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            key_code    <= '0;
            event_valid <= 1'b0;
            key_held    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code    <= key_code_d;
            event_valid <= event_valid_d;
            key_held    <= key_held_d;
            overflow    <= overflow_d;
        end
    end

    // Debounce FSM: advances only on frame_done.
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        key_held_d = key_held;
        accept     = 1'b0;

        if (frame_done) begin
            unique case (state_q)
                IDLE: begin
                    if (frame_sum == SINGLE) begin
                        cand_d = frame_code;
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d    = HELD;
                            cnt_d      = '0;
                            key_held_d = 1'b1;
                            accept     = 1'b1;
                        end else begin
                            state_d = CONFIRM;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                CONFIRM: begin
                    if (frame_sum == SINGLE && frame_code == cand_q) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d    = HELD;
                            cnt_d      = '0;
                            key_held_d = 1'b1;
                            accept     = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (frame_sum == SINGLE) begin
                        cand_d = frame_code;
                        cnt_d  = CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                HELD: begin
                    // Other keys are ignored here; only the locked key matters.
                    if (cand_present) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d    = IDLE;
                        cnt_d      = '0;
                        key_held_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Event register: a raise during a pending, unaccepted event overwrites it.
    always_comb begin
        event_valid_d = event_valid;
        key_code_d    = key_code;
        overflow_d    = overflow;

        if (event_valid && event_ready) begin
            event_valid_d = 1'b0;
        end
        if (accept || repeat_fire) begin
            event_valid_d = 1'b1;
            key_code_d    = cand_d;
            if (event_valid && !event_ready) begin
                overflow_d = 1'b1;
            end
        end
    end

`ifdef KEYB_TYPEMATIC_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = code_width(REP_MAX + 2);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_RATE);

    logic [REP_W-1:0] rep_cnt_q;
    logic [REP_W-1:0] rep_cnt_inc;
    logic [REP_W-1:0] rep_target;
    logic             rep_phase_q;

    // The count saturates at the target while the key bounces, so a repeat
    // fires on the first frame the key is seen again.
    always_comb begin
        rep_target  = rep_phase_q ? REP_NEXT : REP_FIRST;
        rep_cnt_inc = rep_cnt_q + REP_W'(1);
        repeat_fire = frame_done && (state_q == HELD) && cand_present
                      && (rep_cnt_inc >= rep_target);
    end

    always_ff @(posedge clk) begin
        if (!reset || state_q != HELD) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
        end else if (repeat_fire) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b1;
        end else if (frame_done && rep_cnt_q < rep_target) begin
            rep_cnt_q   <= rep_cnt_inc;
        end
    end
`else
    // Repeat parameters have no effect in this build.
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_repeat_unused
    end
    assign repeat_fire = 1'b0;
`endif

endmodule
